cicero_job_sequencer: RTL and testbench
=======================================

// Module: cicero_job_sequencer
// PURPOSE
//  Hardware master for AXI_top's command/status register interface. Replaces host-driven start/poll/read.
//  Accepts one job descriptor (string start/end pointers) per valid/ready handshake.
//  Issues CMD_START, polls status_register until the run completes, then reads the elapsed clock count.
//  Returns accept/reject, elapsed cycles and an error code on a valid/ready result port.
//  Sits between the host/DMA job queue and AXI_top; code/string loading stays outside this block.
// PARAMETERS
//  START_HOLD      2          cycles CMD_START is held; status is checked on the last one (>=1)
//  READ_LATENCY    1          cycles from cmd_o=CMD_READ_ELAPSED_CLOCK to data_o_i valid (>=1)
//  TIMEOUT_CYCLES  1_000_000  max cycles spent in WAIT; 0 disables the timeout
//  CNT_WIDTH       32         width of the timeout and statistics counters
// PORTS
//  clk               in   1          clock
//  rst               in   1          synchronous, active-high reset
//  job_valid         in   1          job descriptor valid
//  job_ready         out  1          sequencer can take a job
//  job_start_ptr     in   REG_WIDTH  first string byte address
//  job_end_ptr       in   REG_WIDTH  last string byte address (inclusive)
//  start_cc_ptr_o    out  REG_WIDTH  to AXI_top start_cc_pointer_register
//  end_cc_ptr_o      out  REG_WIDTH  to AXI_top end_cc_pointer_register
//  cmd_o             out  REG_WIDTH  to AXI_top cmd_register
//  status_i          in   REG_WIDTH  from AXI_top status_register
//  data_o_i          in   REG_WIDTH  from AXI_top data_o_register
//  res_valid         out  1          result valid
//  res_ready         in   1          result consumed
//  res_accept        out  1          1 = STATUS_ACCEPTED
//  res_err           out  2          seq_err_t
//  res_cc            out  REG_WIDTH  elapsed clocks; 0 on error
//  busy              out  1          FSM not in IDLE
//  jobs_done         out  CNT_WIDTH  results handed off since reset (wraps)
// BEHAVIOUR
//  Reset (sync, active-high, dominant over all inputs)
//   - All outputs are registered.
//   - Reset values: cmd_o=CMD_NOP, pointers=0, job_ready=0, res_*=0, busy=0, jobs_done=0; FSM=IDLE.
//   - Mid-job reset aborts the job immediately. No result is emitted; AXI_top is not sent any further command.
//   - job_ready rises in the first cycle after reset deasserts.
//  FSM (one state per cycle unless noted)
//   IDLE: job_ready=1. On job_valid&job_ready: latch pointers into start_cc_ptr_o/end_cc_ptr_o, job_ready=0 -> LOAD.
//   LOAD: pointers stable, cmd_o=CMD_NOP, clear timeout counter -> START.
//   START: cmd_o=CMD_START for START_HOLD cycles. On the last cycle sample status_i:
//     - ==STATUS_RUNNING -> WAIT, with cmd_o=CMD_NOP from the next cycle;
//     - otherwise -> RESP with err=ERR_START.
//   WAIT: cmd_o=CMD_NOP; the counter increments each cycle. Exit checks, in priority order:
//     - status_i==STATUS_ACCEPTED or STATUS_REJECTED -> READ, latch res_accept;
//     - status_i!=RUNNING, not a final status -> RESP, err=ERR_STATUS;
//     - TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 -> RESP, err=ERR_TIMEOUT.
//     - Completion seen in the same cycle as the timeout terminal count wins.
//   READ: cmd_o=CMD_READ_ELAPSED_CLOCK for one cycle. Capture data_o_i READ_LATENCY cycles later into res_cc.
//     cmd_o returns to CMD_NOP after that one cycle -> RESP.
//   RESP: res_valid=1; all res_* fields held stable until res_ready.
//     - On handshake: jobs_done+=1 -> IDLE.
//     - res_ready may be high on the first RESP cycle: a one-cycle handshake.
//     - job_ready is never asserted in RESP: no same-cycle job accept.
//  Error paths: res_cc=0 and res_accept=0; pointers are retained for debug.
//  Pointers are held from LOAD until the next accepted job.
//  job_* inputs are ignored outside IDLE.
//  Counters wrap modulo 2^CNT_WIDTH. TIMEOUT_CYCLES must be < 2^CNT_WIDTH.
//  Minimum job latency, accept to res_valid: 1+START_HOLD+1+READ_LATENCY+1 cycles, with WAIT lasting 1 cycle.
// STRUCTURE
//  AXI_package provides CMD_*, STATUS_* and REG_WIDTH; no local copies.
//  Shared package additions:
//   - typedef enum logic[1:0] seq_err_t {ERR_NONE, ERR_START, ERR_STATUS, ERR_TIMEOUT};
//   - typedef enum seq_state_t {IDLE, LOAD, START, WAIT, READ, RESP}.
//  Single module; no sub-modules. The timeout counter and hold/latency counters are inline.
// TESTING (bench uses a behavioural AXI_top status/data model)
//  1. Job 0x100..0x1FF; model goes RUNNING 1 cycle after CMD_START, ACCEPTED after 50 cycles, data_o=0x3A.
//     -> cmd_o sequence NOP,START x2,NOP..,READ_ELAPSED,NOP.
//     -> res: accept=1, err=0, cc=0x3A; jobs_done=1.
//  2. Model returns REJECTED after 10 cycles -> res_accept=0, err=ERR_NONE, cc=model value.
//  3. Model stays IDLE after CMD_START -> res_err=ERR_START, cc=0; no CMD_READ_ELAPSED_CLOCK issued.
//  4. TIMEOUT_CYCLES=100, model stuck RUNNING -> err=ERR_TIMEOUT exactly 100 WAIT cycles after entry.
//     Completion exactly at cycle 99 -> normal result.
//  5. Hold res_ready=0 for 20 cycles with job_valid high:
//     -> res_* stable, job_ready=0, no new CMD_START; after the handshake the next job is accepted in IDLE.
//  6. Assert rst during WAIT -> next cycle cmd_o=CMD_NOP, res_valid=0, busy=0, jobs_done=0;
//     a fresh job afterwards completes normally.

Source files
------------

// File: rtl/AXI_package.sv
// Register map shared with AXI_top: command codes, status codes and register width.
package AXI_package;

   localparam int REG_WIDTH = 32;

   localparam logic [REG_WIDTH-1:0] CMD_NOP                = REG_WIDTH'(0);
   localparam logic [REG_WIDTH-1:0] CMD_WRITE              = REG_WIDTH'(1);
   localparam logic [REG_WIDTH-1:0] CMD_READ               = REG_WIDTH'(2);
   localparam logic [REG_WIDTH-1:0] CMD_START              = REG_WIDTH'(3);
   localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = REG_WIDTH'(4);

   localparam logic [REG_WIDTH-1:0] STATUS_IDLE     = REG_WIDTH'(0);
   localparam logic [REG_WIDTH-1:0] STATUS_RUNNING  = REG_WIDTH'(1);
   localparam logic [REG_WIDTH-1:0] STATUS_ACCEPTED = REG_WIDTH'(2);
   localparam logic [REG_WIDTH-1:0] STATUS_REJECTED = REG_WIDTH'(3);
   localparam logic [REG_WIDTH-1:0] STATUS_ERROR    = REG_WIDTH'(4);

endpackage

// File: rtl/cicero_job_sequencer_pkg.sv
// Types used by the job sequencer that drives AXI_top's command/status registers.
package cicero_job_sequencer_pkg;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_START,
      ERR_STATUS,
      ERR_TIMEOUT
   } seq_err_t;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT,
      READ,
      RESP
   } seq_state_t;

endpackage

// File: rtl/cicero_job_sequencer.sv
// Hardware master for AXI_top: takes a job descriptor, starts the engine, polls status,
// reads the elapsed clock count and returns the outcome on a valid/ready result port.
module cicero_job_sequencer
   import AXI_package::*;
   import cicero_job_sequencer_pkg::*;
#(
   parameter int unsigned START_HOLD     = 2,
   parameter int unsigned READ_LATENCY   = 1,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
   parameter int unsigned CNT_WIDTH      = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 job_valid,
   output logic                 job_ready,
   input  logic [REG_WIDTH-1:0] job_start_ptr,
   input  logic [REG_WIDTH-1:0] job_end_ptr,
   output logic [REG_WIDTH-1:0] start_cc_ptr_o,
   output logic [REG_WIDTH-1:0] end_cc_ptr_o,
   output logic [REG_WIDTH-1:0] cmd_o,
   input  logic [REG_WIDTH-1:0] status_i,
   input  logic [REG_WIDTH-1:0] data_o_i,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic                 res_accept,
   output logic [1:0]           res_err,
   output logic [REG_WIDTH-1:0] res_cc,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] jobs_done
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(START_HOLD - 1);
   localparam logic [CNT_WIDTH-1:0] LAT_LAST  = CNT_WIDTH'(READ_LATENCY);
   localparam logic [CNT_WIDTH-1:0] TO_LAST   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam bit                   TO_EN     = (TIMEOUT_CYCLES != 0);

   seq_state_t           state, state_nxt;
   seq_err_t             res_err_q, res_err_nxt;
   logic [CNT_WIDTH-1:0] to_cnt, to_cnt_nxt;
   logic [CNT_WIDTH-1:0] phase_cnt, phase_cnt_nxt;
   logic                 job_ready_nxt;
   logic [REG_WIDTH-1:0] start_ptr_nxt, end_ptr_nxt, cmd_nxt, res_cc_nxt;
   logic                 res_valid_nxt, res_accept_nxt, busy_nxt;
   logic [CNT_WIDTH-1:0] jobs_done_nxt;

   assign res_err = res_err_q;

   // phase_cnt counts CMD_START hold cycles in START and read latency cycles in READ.
   always_comb begin
      state_nxt      = state;
      res_err_nxt    = res_err_q;
      to_cnt_nxt     = to_cnt;
      phase_cnt_nxt  = phase_cnt;
      job_ready_nxt  = 1'b0;
      start_ptr_nxt  = start_cc_ptr_o;
      end_ptr_nxt    = end_cc_ptr_o;
      cmd_nxt        = cmd_o;
      res_valid_nxt  = res_valid;
      res_accept_nxt = res_accept;
      res_cc_nxt     = res_cc;
      jobs_done_nxt  = jobs_done;

      case (state)
         IDLE: begin
            cmd_nxt       = CMD_NOP;
            job_ready_nxt = 1'b1;
            if (job_valid && job_ready) begin
               start_ptr_nxt = job_start_ptr;
               end_ptr_nxt   = job_end_ptr;
               job_ready_nxt = 1'b0;
               state_nxt     = LOAD;
            end
         end

         LOAD: begin
            cmd_nxt       = CMD_START;
            to_cnt_nxt    = '0;
            phase_cnt_nxt = '0;
            state_nxt     = START;
         end

         START: begin
            if (phase_cnt == HOLD_LAST) begin
               cmd_nxt = CMD_NOP;
               if (status_i == STATUS_RUNNING) begin
                  state_nxt = WAIT;
               end else begin
                  res_valid_nxt  = 1'b1;
                  res_err_nxt    = ERR_START;
                  res_accept_nxt = 1'b0;
                  res_cc_nxt     = '0;
                  state_nxt      = RESP;
               end
            end else begin
               phase_cnt_nxt = phase_cnt + CNT_ONE;
            end
         end

         // Completion is checked before the timeout so a finish on the terminal count still wins.
         WAIT: begin
            cmd_nxt = CMD_NOP;
            if (status_i == STATUS_ACCEPTED || status_i == STATUS_REJECTED) begin
               res_accept_nxt = (status_i == STATUS_ACCEPTED);
               res_err_nxt    = ERR_NONE;
               cmd_nxt        = CMD_READ_ELAPSED_CLOCK;
               phase_cnt_nxt  = '0;
               state_nxt      = READ;
            end else if (status_i != STATUS_RUNNING) begin
               res_valid_nxt  = 1'b1;
               res_err_nxt    = ERR_STATUS;
               res_accept_nxt = 1'b0;
               res_cc_nxt     = '0;
               state_nxt      = RESP;
            end else if (TO_EN && to_cnt == TO_LAST) begin
               res_valid_nxt  = 1'b1;
               res_err_nxt    = ERR_TIMEOUT;
               res_accept_nxt = 1'b0;
               res_cc_nxt     = '0;
               state_nxt      = RESP;
            end else begin
               to_cnt_nxt = to_cnt + CNT_ONE;
            end
         end

         READ: begin
            cmd_nxt = CMD_NOP;
            if (phase_cnt == LAT_LAST) begin
               res_cc_nxt    = data_o_i;
               res_valid_nxt = 1'b1;
               state_nxt     = RESP;
            end else begin
               phase_cnt_nxt = phase_cnt + CNT_ONE;
            end
         end

         RESP: begin
            cmd_nxt = CMD_NOP;
            if (res_ready) begin
               res_valid_nxt = 1'b0;
               jobs_done_nxt = jobs_done + CNT_ONE;
               job_ready_nxt = 1'b1;
               state_nxt     = IDLE;
            end
         end

         default: begin
            cmd_nxt   = CMD_NOP;
            state_nxt = IDLE;
         end
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         res_err_q      <= ERR_NONE;
         to_cnt         <= '0;
         phase_cnt      <= '0;
         job_ready      <= 1'b0;
         start_cc_ptr_o <= '0;
         end_cc_ptr_o   <= '0;
         cmd_o          <= CMD_NOP;
         res_valid      <= 1'b0;
         res_accept     <= 1'b0;
         res_cc         <= '0;
         busy           <= 1'b0;
         jobs_done      <= '0;
      end else begin
         state          <= state_nxt;
         res_err_q      <= res_err_nxt;
         to_cnt         <= to_cnt_nxt;
         phase_cnt      <= phase_cnt_nxt;
         job_ready      <= job_ready_nxt;
         start_cc_ptr_o <= start_ptr_nxt;
         end_cc_ptr_o   <= end_ptr_nxt;
         cmd_o          <= cmd_nxt;
         res_valid      <= res_valid_nxt;
         res_accept     <= res_accept_nxt;
         res_cc         <= res_cc_nxt;
         busy           <= busy_nxt;
         jobs_done      <= jobs_done_nxt;
      end
   end

endmodule

// File: tb/tb_cicero_job_sequencer.sv
// Directed bench for cicero_job_sequencer against a behavioural AXI_top status/data model.
module tb_cicero_job_sequencer;
   import AXI_package::*;
   import cicero_job_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        job_valid;
   logic        job_ready;
   logic [31:0] job_start_ptr, job_end_ptr;
   logic [31:0] start_cc_ptr_o, end_cc_ptr_o, cmd_o;
   logic [31:0] status_i, data_o_i;
   logic        res_valid, res_ready, res_accept;
   logic [1:0]  res_err;
   logic [31:0] res_cc;
   logic        busy;
   logic [31:0] jobs_done;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   bit          model_stay_idle;
   bit          model_stuck;
   int          model_run_len;
   logic [31:0] model_final;
   logic [31:0] model_data;
   int          run_cnt      = 0;
   int          start_cycles = 0;
   int          read_cycles  = 0;

   cicero_job_sequencer #(
      .START_HOLD     (2),
      .READ_LATENCY   (1),
      .TIMEOUT_CYCLES (100),
      .CNT_WIDTH      (32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .job_valid      (job_valid),
      .job_ready      (job_ready),
      .job_start_ptr  (job_start_ptr),
      .job_end_ptr    (job_end_ptr),
      .start_cc_ptr_o (start_cc_ptr_o),
      .end_cc_ptr_o   (end_cc_ptr_o),
      .cmd_o          (cmd_o),
      .status_i       (status_i),
      .data_o_i       (data_o_i),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_accept     (res_accept),
      .res_err        (res_err),
      .res_cc         (res_cc),
      .busy           (busy),
      .jobs_done      (jobs_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // AXI_top stand-in: RUNNING one cycle after CMD_START, final status after model_run_len cycles.
   always @(posedge clk) begin
      if (rst) begin
         status_i <= STATUS_IDLE;
         data_o_i <= 32'h0;
         run_cnt  <= 0;
      end else begin
         if (cmd_o == CMD_START) begin
            start_cycles <= start_cycles + 1;
            status_i     <= model_stay_idle ? STATUS_IDLE : STATUS_RUNNING;
            run_cnt      <= 0;
         end else if (status_i == STATUS_RUNNING && !model_stuck) begin
            if (run_cnt == model_run_len - 1) status_i <= model_final;
            run_cnt <= run_cnt + 1;
         end
         if (cmd_o == CMD_READ_ELAPSED_CLOCK) begin
            read_cycles <= read_cycles + 1;
            data_o_i    <= model_data;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
         else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
         end
   endtask

   // Called on a negedge; returns on the negedge after the accepting edge with cyc recorded.
   task automatic applyStimulus(input logic [31:0] sp, input logic [31:0] ep, output int t_acc);
      int n = 0;
      job_start_ptr = sp;
      job_end_ptr   = ep;
      job_valid     = 1'b1;
      while (job_ready !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("job_ready_seen", {31'b0, job_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      job_valid = 1'b0;
      t_acc = cyc;
   endtask

   task automatic waitResult(output int t_res);
      int n = 0;
      while (res_valid !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("res_valid_seen", {31'b0, res_valid}, 32'd1);
      t_res = cyc;
   endtask

   task automatic waitWaitEntry(output int t_w);
      int n = 0;
      while (cmd_o !== CMD_START && n < 100) begin
         @(negedge clk);
         n++;
      end
      while (cmd_o === CMD_START && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("wait_entry_seen", {31'b0, (n < 200)}, 32'd1);
      t_w = cyc;
   endtask

   task automatic takeResult();
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   initial begin
      int t_acc, t_res, t_w, s0, r0;
      logic [31:0] cc_hold;

      rst = 1'b1;
      job_valid = 1'b0;
      res_ready = 1'b0;
      job_start_ptr = 32'h0;
      job_end_ptr = 32'h0;
      model_stay_idle = 1'b0;
      model_stuck = 1'b0;
      model_run_len = 50;
      model_final = STATUS_ACCEPTED;
      model_data = 32'h3A;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_cmd", cmd_o, CMD_NOP);
      checkOutput("rst_job_ready", {31'b0, job_ready}, 32'd0);
      checkOutput("rst_res_valid", {31'b0, res_valid}, 32'd0);
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_jobs_done", jobs_done, 32'd0);
      checkOutput("rst_start_ptr", start_cc_ptr_o, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("ready_after_rst", {31'b0, job_ready}, 32'd1);

      $display("[TB] job 1: accepted after 50 cycles");
      s0 = start_cycles;
      r0 = read_cycles;
      applyStimulus(32'h100, 32'h1FF, t_acc);
      checkOutput("t1_load_cmd", cmd_o, CMD_NOP);
      checkOutput("t1_load_busy", {31'b0, busy}, 32'd1);
      checkOutput("t1_load_ready", {31'b0, job_ready}, 32'd0);
      checkOutput("t1_start_ptr", start_cc_ptr_o, 32'h100);
      checkOutput("t1_end_ptr", end_cc_ptr_o, 32'h1FF);
      @(negedge clk);
      checkOutput("t1_cmd_start0", cmd_o, CMD_START);
      @(negedge clk);
      checkOutput("t1_cmd_start1", cmd_o, CMD_START);
      @(negedge clk);
      checkOutput("t1_cmd_wait", cmd_o, CMD_NOP);
      waitResult(t_res);
      checkOutput("t1_latency", 32'(t_res - t_acc), 32'd56);
      checkOutput("t1_accept", {31'b0, res_accept}, 32'd1);
      checkOutput("t1_err", {30'b0, res_err}, 32'(ERR_NONE));
      checkOutput("t1_cc", res_cc, 32'h3A);
      checkOutput("t1_cmd_resp", cmd_o, CMD_NOP);
      checkOutput("t1_start_cycles", 32'(start_cycles - s0), 32'd2);
      checkOutput("t1_read_cycles", 32'(read_cycles - r0), 32'd1);
      takeResult();
      checkOutput("t1_valid_drop", {31'b0, res_valid}, 32'd0);
      checkOutput("t1_jobs_done", jobs_done, 32'd1);
      checkOutput("t1_idle_ready", {31'b0, job_ready}, 32'd1);
      checkOutput("t1_idle_busy", {31'b0, busy}, 32'd0);

      $display("[TB] job 2: rejected after 10 cycles");
      model_run_len = 10;
      model_final = STATUS_REJECTED;
      model_data = 32'h77;
      applyStimulus(32'h200, 32'h2FF, t_acc);
      waitResult(t_res);
      checkOutput("t2_latency", 32'(t_res - t_acc), 32'd16);
      checkOutput("t2_accept", {31'b0, res_accept}, 32'd0);
      checkOutput("t2_err", {30'b0, res_err}, 32'(ERR_NONE));
      checkOutput("t2_cc", res_cc, 32'h77);
      takeResult();
      checkOutput("t2_jobs_done", jobs_done, 32'd2);

      $display("[TB] job 3: engine never starts");
      model_stay_idle = 1'b1;
      r0 = read_cycles;
      applyStimulus(32'h300, 32'h3FF, t_acc);
      waitResult(t_res);
      checkOutput("t3_latency", 32'(t_res - t_acc), 32'd3);
      checkOutput("t3_err", {30'b0, res_err}, 32'(ERR_START));
      checkOutput("t3_cc", res_cc, 32'd0);
      checkOutput("t3_accept", {31'b0, res_accept}, 32'd0);
      checkOutput("t3_ptr_kept", start_cc_ptr_o, 32'h300);
      checkOutput("t3_no_read", 32'(read_cycles - r0), 32'd0);
      takeResult();
      checkOutput("t3_jobs_done", jobs_done, 32'd3);
      model_stay_idle = 1'b0;

      $display("[TB] job 4a: stuck RUNNING, timeout");
      model_stuck = 1'b1;
      r0 = read_cycles;
      applyStimulus(32'h400, 32'h4FF, t_acc);
      waitWaitEntry(t_w);
      checkOutput("t4a_wait_entry", 32'(t_w - t_acc), 32'd3);
      waitResult(t_res);
      checkOutput("t4a_wait_len", 32'(t_res - t_w), 32'd100);
      checkOutput("t4a_err", {30'b0, res_err}, 32'(ERR_TIMEOUT));
      checkOutput("t4a_cc", res_cc, 32'd0);
      checkOutput("t4a_accept", {31'b0, res_accept}, 32'd0);
      checkOutput("t4a_no_read", 32'(read_cycles - r0), 32'd0);
      takeResult();
      checkOutput("t4a_jobs_done", jobs_done, 32'd4);

      $display("[TB] job 4b: completion on the terminal count");
      model_stuck = 1'b0;
      model_run_len = 99;
      model_final = STATUS_ACCEPTED;
      model_data = 32'h1234;
      applyStimulus(32'h480, 32'h4FF, t_acc);
      waitResult(t_res);
      checkOutput("t4b_latency", 32'(t_res - t_acc), 32'd105);
      checkOutput("t4b_err", {30'b0, res_err}, 32'(ERR_NONE));
      checkOutput("t4b_accept", {31'b0, res_accept}, 32'd1);
      checkOutput("t4b_cc", res_cc, 32'h1234);
      takeResult();
      checkOutput("t4b_jobs_done", jobs_done, 32'd5);

      $display("[TB] job 5: result back-pressure with job_valid held high");
      model_run_len = 5;
      model_data = 32'h55;
      applyStimulus(32'h500, 32'h5FF, t_acc);
      waitResult(t_res);
      checkOutput("t5_latency", 32'(t_res - t_acc), 32'd11);
      cc_hold = res_cc;
      checkOutput("t5_cc", cc_hold, 32'h55);
      job_start_ptr = 32'h600;
      job_end_ptr = 32'h6FF;
      job_valid = 1'b1;
      s0 = start_cycles;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput("t5_hold_valid", {31'b0, res_valid}, 32'd1);
         checkOutput("t5_hold_ready", {31'b0, job_ready}, 32'd0);
         checkOutput("t5_hold_cc", res_cc, 32'h55);
         checkOutput("t5_hold_accept", {31'b0, res_accept}, 32'd1);
      end
      checkOutput("t5_hold_ptr", start_cc_ptr_o, 32'h500);
      checkOutput("t5_no_start", 32'(start_cycles - s0), 32'd0);
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
      checkOutput("t5_jobs_done", jobs_done, 32'd6);
      checkOutput("t5_idle_ready", {31'b0, job_ready}, 32'd1);
      checkOutput("t5_idle_busy", {31'b0, busy}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      job_valid = 1'b0;
      t_acc = cyc;
      checkOutput("t5_next_busy", {31'b0, busy}, 32'd1);
      checkOutput("t5_next_ptr", start_cc_ptr_o, 32'h600);
      checkOutput("t5_next_end", end_cc_ptr_o, 32'h6FF);

      $display("[TB] job 6: reset during WAIT");
      model_run_len = 30;
      r0 = read_cycles;
      waitWaitEntry(t_w);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("t6_cmd", cmd_o, CMD_NOP);
      checkOutput("t6_res_valid", {31'b0, res_valid}, 32'd0);
      checkOutput("t6_busy", {31'b0, busy}, 32'd0);
      checkOutput("t6_jobs_done", jobs_done, 32'd0);
      checkOutput("t6_ptr", start_cc_ptr_o, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("t6_ready_after", {31'b0, job_ready}, 32'd1);
      checkOutput("t6_no_read", 32'(read_cycles - r0), 32'd0);
      model_run_len = 20;
      model_data = 32'h99;
      s0 = start_cycles;
      applyStimulus(32'h700, 32'h7FF, t_acc);
      waitResult(t_res);
      checkOutput("t6_latency", 32'(t_res - t_acc), 32'd26);
      checkOutput("t6_accept", {31'b0, res_accept}, 32'd1);
      checkOutput("t6_err", {30'b0, res_err}, 32'(ERR_NONE));
      checkOutput("t6_cc", res_cc, 32'h99);
      checkOutput("t6_start_cycles", 32'(start_cycles - s0), 32'd2);
      takeResult();
      checkOutput("t6_jobs_done_after", jobs_done, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
